mem_arbiter: RTL and testbench

//  Single owner of the byte-wide external RAM port. Arbitrates between instruction fetch (ifetch) and the

---
 rtl/mem_arbiter_pkg.sv | 35 +++
 rtl/mem_rd_collector.sv | 56 +++++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the external RAM port arbiter.
//   arb_state_t    - arbiter FSM states
//   ls_size_t      - LSU access size codes (bytes-1; code 2 is illegal, treated as 4 bytes)
//   RAM_IO_ADDRESS - base of the 8-byte memory-mapped IO window
//   ZERO_WORD      - 32-bit zero
//   size_last      - maps a size code to the index of the last byte lane
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IF_RD = 2'd1,
        ARB_LS_RD = 2'd2,
        ARB_LS_WR = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        LS_SIZE_B   = 2'd0,
        LS_SIZE_H   = 2'd1,
        LS_SIZE_RSV = 2'd2,
        LS_SIZE_W   = 2'd3
    } ls_size_t;

    localparam logic [31:0] RAM_IO_ADDRESS = 32'h0003_0000;
    localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;

    // The reserved code 2 behaves as a full word.
    function automatic logic [1:0] size_last(input logic [1:0] sz);
        case (sz)
            LS_SIZE_B: return 2'd0;
            LS_SIZE_H: return 2'd1;
            default:   return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_rd_collector.sv
// mem_rd_collector: byte-lane capture register for serialised reads.
//   clk, rst - clock, async active-high reset
//   clr      - clear lanes and lane index (request accepted)
//   cap      - capture din into lane idx and advance idx
//   last     - index of the last lane of the current access
//   din      - RAM read byte
//   idx      - lane that the next captured byte goes into
//   is_last  - idx is the final lane
//   word     - assembled word including a byte being captured this cycle,
//              zero above the access size
module mem_rd_collector
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        cap,
    input  logic [1:0]  last,
    input  logic [7:0]  din,
    output logic [1:0]  idx,
    output logic        is_last,
    output logic [31:0] word
);

    logic [3:0][7:0] lanes;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes <= '0;
            idx   <= 2'd0;
        end else if (clr) begin
            lanes <= '0;
            idx   <= 2'd0;
        end else if (cap) begin
            lanes[idx] <= din;
            idx        <= idx + 2'd1;
        end
    end

    assign is_last = (idx == last);

    // The byte arriving this cycle is merged in so the owner can register the
    // complete word on the same edge that captures the final lane.
    always_comb begin
        word = ZERO_WORD;
        for (int i = 0; i < 4; i++) begin
            if (2'(i) > last)
                word[8*i +: 8] = 8'h00;
            else if (cap && (2'(i) == idx))
                word[8*i +: 8] = din;
            else
                word[8*i +: 8] = lanes[i];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single owner of the byte-wide RAM port. LSU has fixed priority
// over ifetch; 1/2/4-byte accesses are serialised little-endian.
//   clk, rst                   - clock, async active-high reset
//   rdy                        - global enable (low = freeze, no writes)
//   misbranch_flag             - flush: aborts in-flight reads, blocks acceptance
//   if_req_valid/if_addr       - ifetch word read request
//   if_done/if_rdata           - ifetch completion pulse and word
//   lsu_req_valid/lsu_wr/lsu_size/lsu_addr/lsu_wdata - LSU request
//   lsu_done/lsu_rdata         - LSU completion pulse and raw load bytes
//   mem_din/mem_dout/mem_a/mem_wr - external RAM port
//   io_buffer_full             - UART buffer full
// Build option: MEM_ARB_IO_STALL_EN makes stores to the IO window wait while
// io_buffer_full is high; otherwise io_buffer_full has no effect.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(RAM_IO_ADDRESS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              misbranch_flag,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              lsu_req_valid,
    input  logic              lsu_wr,
    input  logic [1:0]        lsu_size,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [31:0]       lsu_wdata,
    output logic              lsu_done,
    output logic [31:0]       lsu_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    arb_state_t        state;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [1:0]        last;
    logic [2:0]        ia;      // next byte to issue (reads) / current byte (writes)
    logic              pend;    // an address was issued last cycle, its byte is on mem_din

    logic              rd_st, issuing, accept, cap;
    logic              io_hit, io_stall_en, io_stall;
    logic [ADDR_W-1:0] cur_a;
    logic [1:0]        col_idx;
    logic              col_last;
    logic [31:0]       col_word;

    assign rd_st   = (state == ARB_IF_RD) || (state == ARB_LS_RD);
    assign issuing = rd_st && (ia <= {1'b0, last});
    assign cur_a   = addr + ADDR_W'(ia);

    // No acceptance in the done cycle (requester turnaround) or under flush.
    assign accept = (state == ARB_IDLE) && rdy && !misbranch_flag && !if_done && !lsu_done
                    && (lsu_req_valid || if_req_valid);
    assign cap    = rd_st && rdy && !misbranch_flag && pend;

    assign io_hit = (cur_a - IO_ADDR) < ADDR_W'(8);
`ifdef MEM_ARB_IO_STALL_EN
    assign io_stall_en = 1'b1;
`else
    assign io_stall_en = 1'b0;
`endif
    assign io_stall = io_stall_en && io_hit && io_buffer_full;

    assign mem_wr   = (state == ARB_LS_WR) && rdy && !io_stall;
    assign mem_a    = (issuing || state == ARB_LS_WR) ? cur_a : '0;
    assign mem_dout = (state == ARB_LS_WR) ? wdata[{ia[1:0], 3'b000} +: 8] : 8'h00;

    mem_rd_collector u_col (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .cap     (cap),
        .last    (last),
        .din     (mem_din),
        .idx     (col_idx),
        .is_last (col_last),
        .word    (col_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB_IDLE;
            addr      <= '0;
            wdata     <= ZERO_WORD;
            last      <= 2'd0;
            ia        <= 3'd0;
            pend      <= 1'b0;
            if_done   <= 1'b0;
            lsu_done  <= 1'b0;
            if_rdata  <= ZERO_WORD;
            lsu_rdata <= ZERO_WORD;
        end else begin
            if_done  <= 1'b0;
            lsu_done <= 1'b0;
            if (rdy) begin
                case (state)
                    ARB_IDLE: begin
                        if (accept) begin
                            ia   <= 3'd0;
                            pend <= 1'b0;
                            if (lsu_req_valid) begin
                                addr  <= lsu_addr;
                                wdata <= lsu_wdata;
                                last  <= size_last(lsu_size);
                                state <= lsu_wr ? ARB_LS_WR : ARB_LS_RD;
                            end else begin
                                addr  <= if_addr;
                                last  <= 2'd3;
                                state <= ARB_IF_RD;
                            end
                        end
                    end
                    ARB_IF_RD, ARB_LS_RD: begin
                        if (misbranch_flag) begin
                            state <= ARB_IDLE;
                        end else begin
                            pend <= issuing;
                            if (issuing)
                                ia <= ia + 3'd1;
                            if (cap && col_last) begin
                                state <= ARB_IDLE;
                                if (state == ARB_IF_RD) begin
                                    if_done  <= 1'b1;
                                    if_rdata <= col_word;
                                end else begin
                                    lsu_done  <= 1'b1;
                                    lsu_rdata <= col_word;
                                end
                            end
                        end
                    end
                    ARB_LS_WR: begin
                        // Stores are committed and ignore flushes.
                        if (!io_stall) begin
                            if (ia[1:0] == last) begin
                                state    <= ARB_IDLE;
                                lsu_done <= 1'b1;
                            end else begin
                                ia <= ia + 3'd1;
                            end
                        end
                    end
                    default: state <= ARB_IDLE;
                endcase
            end else if (rd_st) begin
                // Frozen read: the byte on mem_din is dropped, so rewind the
                // issue pointer to the first uncaptured lane and fetch it again.
                ia   <= {1'b0, col_idx};
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. A RAM model feeds mem_din;
// a scoreboard (expected read words from RAM contents, expected write byte
// log) is checked every cycle by one compare process, and directed tests pin
// latencies and literal values.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, misbranch_flag, io_buffer_full;
    logic        if_req_valid, lsu_req_valid, lsu_wr;
    logic [31:0] if_addr, lsu_addr, lsu_wdata, if_rdata, lsu_rdata, mem_a;
    logic [1:0]  lsu_size;
    logic [7:0]  mem_din, mem_dout;
    logic        if_done, lsu_done, mem_wr;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .misbranch_flag(misbranch_flag),
        .if_req_valid(if_req_valid), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_wr(lsu_wr), .lsu_size(lsu_size), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    // ---------------- RAM model ----------------
    logic [7:0] ram [logic [31:0]];

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    always @(posedge clk) mem_din <= ram_rd(mem_a);

    // ---------------- model / scoreboard ----------------
    typedef struct packed { logic st; logic [31:0] d; } lexp_t;
    logic [31:0] q_if [$];
    lexp_t       q_ls [$];
    logic [39:0] q_w  [$];
    logic [31:0] last_if, last_ls;
    bit          sb_off = 1'b0;
    int          n_cmp = 0, n_bad = 0;

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] w = 32'h0;
        for (int k = 0; k < nbytes(sz); k++) w[8*k +: 8] = ram_rd(a + 32'(k));
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic exp_load(input logic [31:0] a, input logic [1:0] sz);
        lexp_t e;
        e.st = 1'b0;
        e.d  = model_rd(a, sz);
        q_ls.push_back(e);
    endtask

    task automatic exp_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        lexp_t e;
        for (int k = 0; k < nbytes(sz); k++) q_w.push_back({a + 32'(k), wd[8*k +: 8]});
        e.st = 1'b1;
        e.d  = 32'h0;
        q_ls.push_back(e);
    endtask

    logic [31:0] ce_if;
    lexp_t       ce_ls;
    logic [39:0] ce_w;

    always @(negedge clk) begin
        if (rst) begin
            q_if.delete(); q_ls.delete(); q_w.delete();
            last_if = 32'h0;
            last_ls = 32'h0;
        end else if (!sb_off) begin
            chk("dual_done", {31'b0, if_done & lsu_done}, 32'h0);
            chk("wr_while_frozen", {31'b0, mem_wr & ~rdy}, 32'h0);
            if (if_done) begin
                if (q_if.size() == 0) chk("if_spurious_done", {31'b0, if_done}, 32'h0);
                else begin
                    ce_if = q_if.pop_front();
                    chk("if_rdata", if_rdata, ce_if);
                    last_if = ce_if;
                end
            end else chk("if_rdata_hold", if_rdata, last_if);
            if (lsu_done) begin
                if (q_ls.size() == 0) chk("lsu_spurious_done", {31'b0, lsu_done}, 32'h0);
                else begin
                    ce_ls = q_ls.pop_front();
                    if (ce_ls.st) chk("lsu_rdata_store_hold", lsu_rdata, last_ls);
                    else begin
                        chk("lsu_rdata", lsu_rdata, ce_ls.d);
                        last_ls = ce_ls.d;
                    end
                end
            end else chk("lsu_rdata_hold", lsu_rdata, last_ls);
            if (mem_wr) begin
                if (q_w.size() == 0) chk("wr_spurious", {31'b0, mem_wr}, 32'h0);
                else begin
                    ce_w = q_w.pop_front();
                    chk("wr_addr", mem_a, ce_w[39:8]);
                    chk("wr_data", {24'h0, mem_dout}, {24'h0, ce_w[7:0]});
                end
            end
        end
    end

    // ---------------- stimulus engine ----------------
    int          cyc_no, if_dc, ls_dc, flush_at, rdy_lo_a, rdy_lo_b, io_a, io_b, redir_at;
    logic [31:0] redir_addr;
    bit          drop_if, drop_ls;
    logic [31:0] tr_a  [0:63];
    logic        tr_wr [0:63];
    logic [7:0]  tr_do [0:63];

    task automatic tick();
        @(posedge clk); #1;
        if (drop_if) begin if_req_valid = 1'b0; drop_if = 1'b0; end
        if (drop_ls) begin lsu_req_valid = 1'b0; drop_ls = 1'b0; end
        cyc_no++;
        misbranch_flag = (cyc_no == flush_at);
        rdy            = !(cyc_no >= rdy_lo_a && cyc_no <= rdy_lo_b);
        io_buffer_full = (cyc_no >= io_a && cyc_no <= io_b);
        if (cyc_no == redir_at) if_addr = redir_addr;
        @(negedge clk);
        if (cyc_no < 64) begin
            tr_a[cyc_no] = mem_a; tr_wr[cyc_no] = mem_wr; tr_do[cyc_no] = mem_dout;
        end
        if (if_done)  begin if_dc = cyc_no; drop_if = 1'b1; end
        if (lsu_done) begin ls_dc = cyc_no; drop_ls = 1'b1; end
    endtask

    task automatic begin_test();
        @(posedge clk); #1;
        cyc_no = 0; if_dc = -1; ls_dc = -1;
        flush_at = -1; rdy_lo_a = -1; rdy_lo_b = -2; io_a = -1; io_b = -2; redir_at = -1;
        rdy = 1'b1; misbranch_flag = 1'b0; io_buffer_full = 1'b0;
        for (int i = 0; i < 64; i++) begin tr_a[i] = 32'h0; tr_wr[i] = 1'b0; tr_do[i] = 8'h0; end
    endtask

    task automatic run(input string nm, input int maxc);
        while ((if_req_valid || lsu_req_valid) && cyc_no < maxc) tick();
        if (if_req_valid || lsu_req_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL %s timeout: no done within %0d cycles", nm, maxc);
            if_req_valid = 1'b0; lsu_req_valid = 1'b0;
            drop_if = 1'b0; drop_ls = 1'b0;
        end
    endtask

    task automatic lsu_go(input bit wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        lsu_req_valid = 1'b1; lsu_wr = wr; lsu_size = sz; lsu_addr = a; lsu_wdata = wd;
    endtask

    logic [31:0] ea [4];
    logic [7:0]  ed [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; misbranch_flag = 1'b0; io_buffer_full = 1'b0;
        if_req_valid = 1'b0; lsu_req_valid = 1'b0; lsu_wr = 1'b0; lsu_size = 2'd0;
        if_addr = 32'h0; lsu_addr = 32'h0; lsu_wdata = 32'h0;
        drop_if = 1'b0; drop_ls = 1'b0;
        ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
        ram[32'h1004] = 8'h6F; ram[32'h1005] = 8'h00; ram[32'h1006] = 8'h00; ram[32'h1007] = 8'h00;
        ram[32'h2000] = 8'h11; ram[32'h2001] = 8'h22; ram[32'h2002] = 8'h7F; ram[32'h2003] = 8'h80;
        ram[32'h4000] = 8'h93; ram[32'h4001] = 8'h00; ram[32'h4002] = 8'h10; ram[32'h4003] = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_wr",   {31'b0, mem_wr}, 32'h0);
        chk("rst_mem_a",    mem_a, 32'h0);
        chk("rst_mem_dout", {24'h0, mem_dout}, 32'h0);
        chk("rst_if_done",  {31'b0, if_done}, 32'h0);
        chk("rst_lsu_done", {31'b0, lsu_done}, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_lsu_rdata", lsu_rdata, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: reset in the middle of a word store
        begin_test();
        sb_off = 1'b1;
        lsu_go(1'b1, 2'd3, 32'h100, 32'h12345678);
        tick(); tick();
        chk("t1_wr_active", {31'b0, tr_wr[2]}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("t1_mem_wr",   {31'b0, mem_wr}, 32'h0);
        chk("t1_mem_a",    mem_a, 32'h0);
        chk("t1_lsu_done", {31'b0, lsu_done}, 32'h0);
        lsu_req_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        sb_off = 1'b0;

        // 2: ifetch word from 0x1000 (starts from IDLE after the reset above)
        begin_test();
        q_if.push_back(model_rd(32'h1000, 2'd3));
        if_req_valid = 1'b1; if_addr = 32'h1000;
        run("t2", 20);
        chk("t2_if_done_cycle", if_dc, 6);
        for (int c = 1; c <= 4; c++) begin
            chk("t2_mem_a", tr_a[c], 32'h1000 + 32'(c) - 32'h1);
            chk("t2_mem_wr", {31'b0, tr_wr[c]}, 32'h0);
        end
        chk("t2_if_rdata", if_rdata, 32'h0000_0513);

        // 3: simultaneous requests, LSU lb wins, ifetch follows
        begin_test();
        exp_load(32'h2003, 2'd0);
        q_if.push_back(model_rd(32'h1004, 2'd3));
        lsu_go(1'b0, 2'd0, 32'h2003, 32'h0);
        if_req_valid = 1'b1; if_addr = 32'h1004;
        run("t3", 30);
        chk("t3_lsu_done_cycle", ls_dc, 3);
        chk("t3_lsu_rdata", lsu_rdata, 32'h0000_0080);
        chk("t3_if_first_addr", tr_a[5], 32'h1004);
        chk("t3_if_done_cycle", if_dc, 10);
        chk("t3_if_rdata", if_rdata, 32'h0000_006F);

        // 4: sw across the address wrap
        begin_test();
        exp_store(32'hFFFF_FFFE, 2'd3, 32'hDEAD_BEEF);
        lsu_go(1'b1, 2'd3, 32'hFFFF_FFFE, 32'hDEAD_BEEF);
        run("t4", 20);
        ea = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        ed = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int c = 1; c <= 4; c++) begin
            chk("t4_mem_a", tr_a[c], ea[c-1]);
            chk("t4_mem_dout", {24'h0, tr_do[c]}, {24'h0, ed[c-1]});
            chk("t4_mem_wr", {31'b0, tr_wr[c]}, 32'h1);
        end
        chk("t4_lsu_done_cycle", ls_dc, 5);

        // 5a: flush in cycle 2 of an ifetch, fetcher redirects to 0x4000 in cycle 3
        begin_test();
        q_if.push_back(model_rd(32'h4000, 2'd3));
        if_req_valid = 1'b1; if_addr = 32'h1000;
        flush_at = 2; redir_at = 3; redir_addr = 32'h4000;
        run("t5a", 30);
        chk("t5a_redirect_addr", tr_a[4], 32'h4000);
        chk("t5a_if_done_cycle", if_dc, 9);
        chk("t5a_if_rdata", if_rdata, 32'h0010_0093);

        // 5b: same flush during sh still completes
        begin_test();
        exp_store(32'h3000, 2'd1, 32'h0000_A55A);
        lsu_go(1'b1, 2'd1, 32'h3000, 32'h0000_A55A);
        flush_at = 2;
        run("t5b", 20);
        chk("t5b_lsu_done_cycle", ls_dc, 3);

        // 6: sb to the IO window with the buffer full for cycles 1..3
        begin_test();
        exp_store(32'h0003_0000, 2'd0, 32'h0000_0077);
        lsu_go(1'b1, 2'd0, 32'h0003_0000, 32'h0000_0077);
        io_a = 1; io_b = 3;
        run("t6", 20);
`ifdef MEM_ARB_IO_STALL_EN
        for (int c = 1; c <= 3; c++) chk("t6_io_hold", {31'b0, tr_wr[c]}, 32'h0);
        chk("t6_wr", {31'b0, tr_wr[4]}, 32'h1);
        chk("t6_lsu_done_cycle", ls_dc, 5);
`else
        chk("t6_wr", {31'b0, tr_wr[1]}, 32'h1);
        chk("t6_lsu_done_cycle", ls_dc, 2);
`endif

        // 6b: sb with rdy low for cycles 1..2, exactly one write
        begin_test();
        exp_store(32'h0003_0001, 2'd0, 32'h0000_0066);
        lsu_go(1'b1, 2'd0, 32'h0003_0001, 32'h0000_0066);
        rdy_lo_a = 1; rdy_lo_b = 2;
        run("t6b", 20);
        chk("t6b_frozen1", {31'b0, tr_wr[1]}, 32'h0);
        chk("t6b_frozen2", {31'b0, tr_wr[2]}, 32'h0);
        chk("t6b_wr", {31'b0, tr_wr[3]}, 32'h1);
        chk("t6b_lsu_done_cycle", ls_dc, 4);

        // 7: size code 2 reads a full word; lh zero-fills above two bytes
        begin_test();
        exp_load(32'h1000, 2'd2);
        lsu_go(1'b0, 2'd2, 32'h1000, 32'h0);
        run("t7w", 20);
        chk("t7_lw_cycle", ls_dc, 6);
        chk("t7_lw_rdata", lsu_rdata, 32'h0000_0513);
        begin_test();
        exp_load(32'h2002, 2'd1);
        lsu_go(1'b0, 2'd1, 32'h2002, 32'h0);
        run("t7h", 20);
        chk("t7_lh_cycle", ls_dc, 4);
        chk("t7_lh_rdata", lsu_rdata, 32'h0000_807F);

        // 8: rdy low mid-read, the dropped byte is re-fetched
        begin_test();
        exp_load(32'h2000, 2'd1);
        lsu_go(1'b0, 2'd1, 32'h2000, 32'h0);
        rdy_lo_a = 2; rdy_lo_b = 2;
        run("t8", 20);
        chk("t8_lh_rdata", lsu_rdata, 32'h0000_2211);

        begin_test();
        tick(); tick();
        chk("sb_leftover", 32'(q_if.size() + q_ls.size() + q_w.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
